// File: rtl/seq_pattern_tx_if.sv
// Load handshake and serial pattern outputs of seq_pattern_tx.
// The slave side is the transmitter; the master side feeds words.
interface seq_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    modport slave (
        input  load_valid, load_data,
        output load_ready, x, x_valid,
        output busy, done, match_cnt
    );

    modport master (
        output load_valid, load_data,
        input  load_ready, x, x_valid,
        input  busy, done, match_cnt
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Bit-serial "101" pattern source: shifts a word out MSB first
// and counts overlapping "101" occurrences in it.
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             rst,
    seq_pattern_tx_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       hist_q, hist_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        x_d     = 1'b0;
        xv_d    = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        hist_d  = hist_q;

        // Match on the bit currently on x; the last bit is counted on
        // the edge that raises done, so the count is final there.
        if (xv_q) begin
            hist_d = {hist_q[0], x_q};
            if (hist_q == 2'b10 && x_q && cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    sh_d    = bus.load_data << 1;
                    x_d     = bus.load_data[WIDTH-1];
                    xv_d    = 1'b1;
                    idx_d   = IW'(WIDTH - 1);
                    cnt_d   = '0;
                    hist_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (idx_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    x_d   = sh_q[WIDTH-1];
                    xv_d  = 1'b1;
                    sh_d  = sh_q << 1;
                    idx_d = idx_q - IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.busy       = (state_q == SHIFT);
    assign bus.x          = x_q;
    assign bus.x_valid    = xv_q;
    assign bus.done       = done_q;
    assign bus.match_cnt  = cnt_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: vector table, corner
// sequences and random words against a "101" counting model.
module tb_seq_pattern_tx;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_pattern_tx_if #(.WIDTH(W), .CNT_W(4)) bus ();
    seq_pattern_tx_if #(.WIDTH(W), .CNT_W(1)) bus1 ();

    assign bus1.load_valid = bus.load_valid;
    assign bus1.load_data  = bus.load_data;

    seq_pattern_tx #(.WIDTH(W), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seq_pattern_tx #(.WIDTH(W), .CNT_W(1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct {
        logic [W-1:0] data;
        int           exp_cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Count overlapping "101" in the MSB-first bit sequence.
    function automatic int ref_cnt(input logic [W-1:0] d,
                                   input int maxv);
        int c = 0;
        logic [W-1:0] s;
        s = d;
        for (int k = 2; k < W; k++)
            if (s[W+1-k] && !s[W-k] && s[W-1-k]) c++;
        return (c > maxv) ? maxv : c;
    endfunction

    task automatic chk_idle(input string nm);
        chk({nm, "_x"}, 32'(bus.x), 0);
        chk({nm, "_xv"}, 32'(bus.x_valid), 0);
        chk({nm, "_busy"}, 32'(bus.busy), 0);
        chk({nm, "_ready"}, 32'(bus.load_ready), 1);
    endtask

    // Called at the negedge after the accepting edge; returns in
    // the done cycle. inj >= 0 pulses a load at that bit cycle.
    task automatic check_word(input logic [W-1:0] d,
                              input int inj);
        logic [W-1:0] s;
        s = d;
        for (int i = 0; i < W; i++) begin
            chk("bit_x", 32'(bus.x), 32'(s[W-1-i]));
            chk("bit_xv", 32'(bus.x_valid), 1);
            chk("bit_busy", 32'(bus.busy), 1);
            chk("bit_ready", 32'(bus.load_ready), 0);
            chk("bit_done", 32'(bus.done), 0);
            if (i == inj) begin
                bus.load_valid = 1'b1;
                bus.load_data  = '1;
            end else if (inj >= 0 && i == inj + 1) begin
                bus.load_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("end_done", 32'(bus.done), 1);
        chk_idle("end");
        chk("end_cnt", 32'(bus.match_cnt), 32'(ref_cnt(d, 15)));
        chk("sat_cnt", 32'(bus1.match_cnt), 32'(ref_cnt(d, 1)));
    endtask

    task automatic send(input logic [W-1:0] d);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_data  = W'($urandom);
        check_word(d, -1);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'b1010_1101, 3};
        vecs[1] = '{8'b1010_1010, 3};
        vecs[2] = '{8'b1100_1100, 0};
        vecs[3] = '{8'h55, 3};
        vecs[4] = '{8'hFF, 0};
        vecs[5] = '{8'h00, 0};
        vecs[6] = '{8'hB5, 3};

        bus.load_valid = 1'b0;
        bus.load_data  = '0;

        #7;
        chk_idle("rst");
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_cnt", 32'(bus.match_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        chk_idle("rel");

        for (int v = 0; v < 7; v++) begin
            send(vecs[v].data);
            chk("tbl_cnt", 32'(bus.match_cnt), 32'(vecs[v].exp_cnt));
            @(negedge clk);
            chk("tbl_done_pulse", 32'(bus.done), 0);
            chk("tbl_cnt_hold", 32'(bus.match_cnt),
                32'(vecs[v].exp_cnt));
            chk_idle("tbl_post");
        end

        // Back-to-back: valid held, second word taken in done cycle.
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hAD;
        @(negedge clk);
        bus.load_data = 8'h55;
        check_word(8'hAD, -1);
        @(negedge clk);
        bus.load_valid = 1'b0;
        check_word(8'h55, -1);
        chk("b2b_cnt", 32'(bus.match_cnt), 3);
        @(negedge clk);

        // Load pulse during SHIFT is ignored.
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hAD;
        @(negedge clk);
        bus.load_valid = 1'b0;
        check_word(8'hAD, 3);
        @(negedge clk);
        chk_idle("ign_post");

        // Asynchronous reset while bit 4 is on x.
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hAD;
        @(negedge clk);
        bus.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("pre_rst_cnt", 32'(bus.match_cnt), 1);
        chk("pre_rst_busy", 32'(bus.busy), 1);
        #2 rst = 1'b0;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_cnt", 32'(bus.match_cnt), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        @(negedge clk);
        rst = 1'b1;
        chk("rel_done", 32'(bus.done), 0);
        @(negedge clk);
        chk("rel_done2", 32'(bus.done), 0);
        chk_idle("rel2");
        send(8'hAA);
        chk("after_rst_cnt", 32'(bus.match_cnt), 3);

        // Random words with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("gap_xv", 32'(bus.x_valid), 0);
                chk("gap_done", 32'(bus.done), 0);
            end
            send(W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Bit-serial pattern transmitter. Drives the x stream that the overlapping "101" sequence detectors consume.
- Accepts a parallel word through a valid/ready handshake and shifts it out MSB first, one bit per clock, with a qualifying valid.
- Counts the overlapping "101" occurrences in each transmitted word, giving a golden expected-detect count to compare against detector y pulses in self-checking benches.

Parameters:
- WIDTH, 8, number of bits per transmitted word (legal values: 3 or more).
- CNT_W, 4, width of match_cnt. The counter saturates at 2^CNT_W-1.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- load_valid, input, 1, load_data is valid.
- load_ready, output, 1, block can accept a word; equals (state==IDLE).
- load_data, input, WIDTH, word to transmit, MSB first.
- x, output, 1, serial data bit (registered).
- x_valid, output, 1, x carries a pattern bit this cycle (registered).
- busy, output, 1, high while in SHIFT.
- done, output, 1, one-cycle pulse after the last bit of a word.
- match_cnt, output, CNT_W, number of overlapping "101" occurrences in the current or last word.

Behaviour:
- Reset (rst=0, async, any time including mid-word) forces the following immediately:
  - state=IDLE, x=0, x_valid=0, done=0, match_cnt=0, history cleared.
  - load_ready becomes 1 once rst=0 forces IDLE.
- State machine: IDLE, SHIFT.
- IDLE:
  - load_ready=1.
  - On an edge with load_valid=1:
    - capture load_data into the shift register.
    - x<=load_data[WIDTH-1], x_valid<=1.
    - bit index<=WIDTH-1.
    - match_cnt<=0, history<=0.
    - go to SHIFT.
  - Otherwise x=0 and x_valid=0.
- SHIFT:
  - load_ready=0; load_valid is ignored and the word is not captured.
  - Each edge presents the next lower bit on x and decrements the index.
  - x_valid stays 1 for exactly WIDTH consecutive cycles.
  - On the edge that ends the cycle carrying bit 0: x<=0, x_valid<=0, done<=1, state<=IDLE.
- done is high for exactly one cycle, in the first IDLE cycle.
  - load_ready is also 1 in that cycle, so a word may be accepted there.
  - Minimum spacing is therefore WIDTH+1 cycles per word: one x_valid=0 gap cycle between back-to-back words.
- Latency: the first bit appears on x the cycle after the accepting edge. The last bit appears WIDTH cycles after that edge.
- Match counting:
  - A 2-bit history register holds the previous two transmitted bits.
  - It updates on every edge where x_valid=1.
  - If the history is "10" and the current x is 1, match_cnt increments on that edge.
  - Overlap is allowed, so "10101" counts 2.
  - History is cleared per word; matches do not span word boundaries.
  - match_cnt saturates at 2^CNT_W-1 and never wraps.
  - It is final in the done cycle and held until the next accept or reset.
- busy = (state==SHIFT).
- Outputs change only on clock edges, except under asynchronous reset.

Test Plan:
- Reset then a single word:
  - Stimulus: rst=0 for 10 time units, release; load_data=8'b1010_1101 with load_valid for one cycle.
  - Required response: x sequence 1,0,1,0,1,1,0,1 with x_valid high for 8 cycles; done pulses once; match_cnt=3.
- Overlap case:
  - Stimulus: 8'b1010_1010.
  - Required response: match_cnt=3; x returns to 0 and x_valid to 0 after the 8th bit.
- No-match case:
  - Stimulus: 8'b1100_1100.
  - Required response: match_cnt=0; done still pulses once.
- Back-to-back words:
  - Stimulus: load_valid held high with 8'hAD then 8'h55.
  - Required response: second word accepted in the done cycle; exactly one x_valid=0 gap cycle; second match_cnt=3 (01010101 gives 3).
- Load during SHIFT:
  - Stimulus: pulse load_valid=1 with 8'hFF at bit 3 of a word.
  - Required response: ignored; the current word completes unchanged; load_ready=0 throughout SHIFT.
- Reset mid-operation:
  - Stimulus: assert rst=0 asynchronously between edges at bit 4.
  - Required response: x, x_valid, busy and match_cnt go to 0 immediately; load_ready=1; no done pulse; the next word transmits normally.
